pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives enable and flush of PC,
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers from cache handshakes, load-use hazards, taken

---
 rtl/cpu_types_pkg.sv | 53 +++++
 rtl/pipe_hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, pipeline-controller state and stage control vectors.
// front_ctrl() encodes the redirect / load-use / icache-miss priority for the front stages.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {RUN, DWAIT, HALT} pipe_state_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_en_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_flush_t;

  typedef struct packed {
    stage_en_t    en;
    stage_flush_t fl;
  } stage_ctrl_t;

  // Control for a cycle in which the MEM stage is free to advance.
  function automatic stage_ctrl_t front_ctrl(input logic redirect, input logic load_use,
                                             input logic ihit);
    stage_ctrl_t c;
    c.en = '1;
    c.fl = '0;
    if (redirect) begin
      // Squash everything younger than the resolving branch; PC takes the target.
      c.fl.ifid  = 1'b1;
      c.fl.idex  = 1'b1;
      c.fl.exmem = 1'b1;
    end else if (load_use) begin
      c.en.pc   = 1'b0;
      c.en.ifid = 1'b0;
      c.en.idex = 1'b0;
      c.fl.idex = 1'b1;
    end else if (!ihit) begin
      c.en.pc   = 1'b0;
      c.en.ifid = 1'b0;
      c.fl.ifid = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare: load in EX whose destination is a source of the instruction in ID.
module pipe_hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             idex_dMemREN,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             load_use
);

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = idex_dMemREN && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (RUN / DWAIT / HALT).
// Optional perf counters stall_cnt/flush_cnt are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_W = 5
`ifdef PIPE_CTRL_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             idex_dMemREN,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             redirect_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  pipe_state_t  state_q, state_d;
  stage_ctrl_t  front;
  stage_en_t    en;
  stage_flush_t fl;
  logic         load_use;
  logic         redirect_taken;

  pipe_hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .idex_dMemREN(idex_dMemREN),
    .idex_rt     (idex_rt),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .load_use    (load_use)
  );

  always_comb begin
    front          = front_ctrl(redirect_mem, load_use, ihit);
    en             = '0;
    fl             = '0;
    state_d        = state_q;
    redirect_taken = 1'b0;
    if (RST) begin
      fl      = '1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (halt_wb) begin
            state_d = HALT;
          end else if (mem_req && !dhit) begin
            fl.memwb = 1'b1;
            state_d  = DWAIT;
          end else begin
            en             = front.en;
            fl             = front.fl;
            redirect_taken = redirect_mem;
          end
        end
        DWAIT: begin
          // Upstream inputs are held by the freeze, so they are re-evaluated on dhit.
          if (!dhit) begin
            fl.memwb = 1'b1;
          end else begin
            en             = front.en;
            fl             = front.fl;
            redirect_taken = redirect_mem;
            state_d        = RUN;
          end
        end
        HALT: ;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign pc_en       = en.pc;
  assign ifid_en     = en.ifid;
  assign idex_en     = en.idex;
  assign exmem_en    = en.exmem;
  assign memwb_en    = en.memwb;
  assign ifid_flush  = fl.ifid;
  assign idex_flush  = fl.idex;
  assign exmem_flush = fl.exmem;
  assign memwb_flush = fl.memwb;
  assign halt        = (state_q == HALT) && !RST;

`ifdef PIPE_CTRL_PERF_EN
  logic             stall_inc;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign stall_inc = !RST && (state_q != HALT) && !en.pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1))      stall_q <= stall_q + 1'b1;
      if (redirect_taken && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_redirect_taken;
  assign unused_redirect_taken = redirect_taken;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: reference model feeds a scoreboard queue per cycle.
// Define PIPE_CTRL_PERF_EN to also check the perf counters.
module tb_pipeline_ctrl;

  logic       CLK;
  logic       RST;
  logic       ihit, dhit, mem_req, idex_dMemREN, redirect_mem, halt_wb;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
`ifdef PIPE_CTRL_PERF_EN
  localparam int unsigned CntW = 4;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  int m_stall, m_flush;
`endif

  int n_tests, n_fail;
  int m_state;  // 0 RUN, 1 DWAIT, 2 HALT
  logic [9:0] sb[$];

  pipeline_ctrl #(
    .REG_W(5)
`ifdef PIPE_CTRL_PERF_EN
    , .CNT_W(CntW)
`endif
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .mem_req     (mem_req),
    .idex_dMemREN(idex_dMemREN),
    .idex_rt     (idex_rt),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .redirect_mem(redirect_mem),
    .halt_wb     (halt_wb),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .memwb_flush (memwb_flush),
    .halt        (halt)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt (stall_cnt)
    , .flush_cnt (flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Expected {en pc,ifid,idex,exmem,memwb, flush ifid,idex,exmem,memwb, halt}.
  function automatic void model(output logic [9:0] e, output int ns, output logic rt);
    logic [4:0] en;
    logic [3:0] fl;
    logic       h, lu;
    en = '0; fl = '0; h = 1'b0; ns = m_state; rt = 1'b0;
    lu = idex_dMemREN && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    if (RST) begin
      fl = 4'b1111; ns = 0;
    end else if (m_state == 2) begin
      h = 1'b1;
    end else if (m_state == 0 && halt_wb) begin
      ns = 2;
    end else if ((m_state == 0 && mem_req && !dhit) || (m_state == 1 && !dhit)) begin
      fl = 4'b0001; ns = 1;
    end else begin
      ns = 0;
      if (redirect_mem) begin
        en = 5'b11111; fl = 4'b1110; rt = 1'b1;
      end else if (lu) begin
        en = 5'b00011; fl = 4'b0100;
      end else if (!ihit) begin
        en = 5'b00111; fl = 4'b1000;
      end else begin
        en = 5'b11111;
      end
    end
    e = {en, fl, h};
  endfunction

  task automatic tick(input string tag);
    logic [9:0] e, got;
    int         ns;
    logic       rt;
    model(e, ns, rt);
    sb.push_back(e);
    @(negedge CLK);
    got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};
    check(tag, 32'(got), 32'(sb.pop_front()));
`ifdef PIPE_CTRL_PERF_EN
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
`endif
    @(posedge CLK);
`ifdef PIPE_CTRL_PERF_EN
    if (RST) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (m_state != 2 && !e[9] && m_stall < (1 << CntW) - 1) m_stall++;
      if (rt && m_flush < (1 << CntW) - 1) m_flush++;
    end
`endif
    m_state = ns;
    #1;
  endtask

  task automatic drive(input logic r, input logic ih, input logic dh, input logic mr,
                       input logic ld, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                       input logic [4:0] rt_id, input logic rd, input logic hw);
    RST = r; ihit = ih; dhit = dh; mem_req = mr; idex_dMemREN = ld; idex_rt = rt_ex;
    ifid_rs = rs_id; ifid_rt = rt_id; redirect_mem = rd; halt_wb = hw;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; m_state = 0;
`ifdef PIPE_CTRL_PERF_EN
    m_stall = 0; m_flush = 0;
`endif
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("reset0");
    tick("reset1");

`ifdef PIPE_CTRL_PERF_EN
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick("perf_imiss");
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) tick("perf_redirect");
    check("perf_stall4", 32'(stall_cnt), 32'd4);
    check("perf_flush2", 32'(flush_cnt), 32'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (14) tick("perf_sat");
    check("perf_stall_sat", 32'(stall_cnt), 32'd15);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("perf_reset");
`endif

    drive(0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
    tick("run_normal");
    drive(0, 1, 0, 0, 1, 3, 3, 7, 0, 0);
    tick("load_use_rs");
    drive(0, 1, 0, 0, 0, 0, 4, 5, 0, 0);
    tick("after_bubble");
    drive(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    tick("load_r0");
    drive(0, 1, 0, 0, 1, 5, 1, 5, 0, 0);
    tick("load_use_rt");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("imiss");

    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) tick("dwait_hold");
    drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    tick("dwait_dhit");
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick("back_run");

    drive(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    tick("dmiss_over_redirect");
    tick("dwait_redirect_hold");
    drive(0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    tick("dhit_then_redirect");

    drive(0, 0, 0, 0, 1, 3, 3, 0, 1, 0);
    tick("redirect_lu_imiss");

    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick("enter_dwait");
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick("reset_in_dwait");
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("after_reset_run");

    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick("halt_wb");
    drive(0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    repeat (10) tick("halted");
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("halt_reset");
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("halt_exit_run");

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
            (m_state == 0) && ($urandom_range(0, 40) == 0));
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
